// File: rtl/multicycle_control_unit_if.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control_unit_if
// Description : Decoder/datapath-side signal bundle of the multi-cycle control
//               unit. The master modport is the control unit itself; the slave
//               modport is the datapath that consumes the strobes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_unit_if;
    logic [2:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        wb_sel;
    logic [1:0]  trap;
    logic [2:0]  state;
    logic [31:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output ir_write, pc_write, pc_src, reg_write, mem_read, mem_write,
               alu_src_b, alu_op, wb_sel, trap, state, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ir_write, pc_write, pc_src, reg_write, mem_read, mem_write,
               alu_src_b, alu_op, wb_sel, trap, state, retired
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control_unit
// Description : Multi-cycle control FSM (fetch/decode/exec/mem/wb/branch) with
//               sticky trap on illegal opcode or data-memory timeout.
//               Optional macro PERF_CNT_EN enables the retired-instruction
//               counter; otherwise retired reads 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    multicycle_control_unit_if.master bus
);

    localparam int c_CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(MEM_WAIT_MAX);

    localparam logic [2:0] c_OP_LOAD  = 3'b000;
    localparam logic [2:0] c_OP_STORE = 3'b001;
    localparam logic [2:0] c_OP_ADD   = 3'b010;
    localparam logic [2:0] c_OP_SUB   = 3'b011;
    localparam logic [2:0] c_OP_AND   = 3'b100;
    localparam logic [2:0] c_OP_OR    = 3'b101;
    localparam logic [2:0] c_OP_BEQ   = 3'b110;
    localparam logic [2:0] c_OP_ILL   = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op_q;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [1:0]         r_trap;

    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_pc_src;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_wb_sel;

    wire logic w_is_mem_op = (r_op_q == c_OP_LOAD) || (r_op_q == c_OP_STORE);

    // State sequencing, opcode capture, MEM wait counting and trap code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_op_q     <= 3'b000;
            r_wait_cnt <= '0;
            r_trap     <= 2'b00;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_op_q <= bus.opcode;
                    if (bus.opcode == c_OP_ILL) begin
                        r_state <= S_TRAP;
                        r_trap  <= 2'b01;
                    end else if (bus.opcode == c_OP_BEQ) begin
                        r_state <= S_BRANCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_mem_op) begin
                        r_state    <= S_MEM;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (bus.mem_ready) begin
                        r_state <= (r_op_q == c_OP_LOAD) ? S_WB : S_FETCH;
                    end else if ((MEM_WAIT_MAX > 0) && (r_wait_cnt == c_WAIT_MAX)) begin
                        r_state <= S_TRAP;
                        r_trap  <= 2'b10;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                S_WB:     r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Strobe decode from state and latched opcode; reset gates every strobe.
    always_comb begin
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_alu_src_b = 1'b0;
        w_alu_op    = 2'b00;
        w_wb_sel    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: w_ir_write = 1'b1;
                S_EXEC: begin
                    case (r_op_q)
                        c_OP_LOAD, c_OP_STORE: begin
                            w_alu_src_b = 1'b1;
                            w_alu_op    = 2'b00;
                        end
                        c_OP_ADD: w_alu_op = 2'b00;
                        c_OP_SUB: w_alu_op = 2'b01;
                        c_OP_AND: w_alu_op = 2'b10;
                        c_OP_OR:  w_alu_op = 2'b11;
                        default:  w_alu_op = 2'b00;
                    endcase
                end
                S_MEM: begin
                    w_mem_read  = (r_op_q == c_OP_LOAD);
                    w_mem_write = (r_op_q == c_OP_STORE);
                    // A store retires straight out of MEM, so PC advances here.
                    w_pc_write  = (r_op_q == c_OP_STORE) && bus.mem_ready;
                end
                S_WB: begin
                    w_reg_write = 1'b1;
                    w_wb_sel    = (r_op_q == c_OP_LOAD);
                    w_pc_write  = 1'b1;
                end
                S_BRANCH: begin
                    w_alu_op   = 2'b01;
                    w_pc_write = 1'b1;
                    w_pc_src   = bus.zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.ir_write  = w_ir_write;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_src    = w_pc_src;
    assign bus.reg_write = w_reg_write;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.alu_op    = w_alu_op;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.trap      = r_trap;
    assign bus.state     = r_state;

`ifdef PERF_CNT_EN
    logic [31:0] r_retired;

    // Count every PC update; wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if (w_pc_write) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign bus.retired = r_retired;
`else
    assign bus.retired = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_control_unit
// Description : Randomized self-checking bench for multicycle_control_unit.
//               Expected behaviour comes from per-instruction state sequences,
//               latencies and strobe counts derived from the opcode table.
//               Honours PERF_CNT_EN for the retired counter checks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_unit;

    localparam int MEM_WAIT_MAX = 15;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_retired = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] strobes();
        return {bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.alu_src_b, bus.alu_op, bus.wb_sel};
    endfunction

    task automatic check_retired(input string tag);
`ifdef PERF_CNT_EN
        check(tag, bus.retired, exp_retired);
`else
        check(tag, bus.retired, 32'd0);
`endif
    endtask

    // Entered and left during a FETCH cycle, just after the falling edge.
    task automatic run_instr(input logic [2:0] op, input int n, input logic zv);
        logic [2:0] exp_q[$];
        int  k;
        bit  done;
        int  c_ir, c_pcw, c_rw, c_mr, c_mw;
        logic pcsrc_seen, wbsel_seen, srcb_seen;
        logic [1:0] aluop_seen, exp_aluop;
        bit is_load, is_store, is_alu;

        is_load  = (op == 3'd0);
        is_store = (op == 3'd1);
        is_alu   = (op >= 3'd2) && (op <= 3'd5);

        exp_q = '{3'd0, 3'd1};
        if (op == 3'd6) begin
            exp_q.push_back(3'd5);
        end else begin
            exp_q.push_back(3'd2);
            if (is_load || is_store)
                for (int i = 0; i <= n; i++) exp_q.push_back(3'd3);
            if (!is_store) exp_q.push_back(3'd4);
        end

        case (op)
            3'd3:    exp_aluop = 2'b01;
            3'd4:    exp_aluop = 2'b10;
            3'd5:    exp_aluop = 2'b11;
            3'd6:    exp_aluop = 2'b01;
            default: exp_aluop = 2'b00;
        endcase

        done = 0;
        c_ir = 0; c_pcw = 0; c_rw = 0; c_mr = 0; c_mw = 0;
        pcsrc_seen = 1'bx; wbsel_seen = 1'bx; srcb_seen = 1'bx; aluop_seen = 2'bxx;

        for (k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            bus.opcode = (k <= 1) ? op : 3'($urandom);
            bus.zero   = (k == 2) ? zv : 1'($urandom);
            if ((is_load || is_store) && (k >= 3) && (k < 3 + n))
                bus.mem_ready = 1'b0;
            else if ((is_load || is_store) && (k == 3 + n))
                bus.mem_ready = 1'b1;
            else
                bus.mem_ready = 1'($urandom);
            #1;
            if ((k > 0) && (bus.state == 3'd0)) begin
                done = 1;
                break;
            end
            if (k < exp_q.size()) check("state_seq", bus.state, exp_q[k]);
            if (bus.ir_write)  c_ir++;
            if (bus.pc_write)  begin c_pcw++; pcsrc_seen = bus.pc_src; end
            if (bus.reg_write) begin c_rw++;  wbsel_seen = bus.wb_sel; end
            if (bus.mem_read)  c_mr++;
            if (bus.mem_write) c_mw++;
            if (k == 2) begin aluop_seen = bus.alu_op; srcb_seen = bus.alu_src_b; end
        end

        check("completed", 32'(done), 32'd1);
        check("latency", k, exp_q.size());
        check("ir_write_cycles", c_ir, 1);
        check("pc_write_cycles", c_pcw, 1);
        check("pc_src", pcsrc_seen, (op == 3'd6) ? zv : 1'b0);
        check("reg_write_cycles", c_rw, (is_load || is_alu) ? 1 : 0);
        if (is_load || is_alu) check("wb_sel", wbsel_seen, is_load);
        check("mem_read_cycles", c_mr, is_load ? n + 1 : 0);
        check("mem_write_cycles", c_mw, is_store ? n + 1 : 0);
        check("alu_op", aluop_seen, exp_aluop);
        check("alu_src_b", srcb_seen, (is_load || is_store) ? 1'b1 : 1'b0);
        exp_retired++;
        check_retired("retired");
    endtask

    // Asynchronous reset pulse taken mid-cycle; leaves aligned in FETCH.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_state"}, bus.state, 3'd0);
        check({tag, "_trap"}, bus.trap, 2'b00);
        check({tag, "_strobes"}, strobes(), 10'd0);
        exp_retired = 0;
        check_retired({tag, "_retired"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int k;

        reset = 1'b1;
        bus.opcode = 3'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("rst_state", bus.state, 3'd0);
        check("rst_trap", bus.trap, 2'b00);
        check("rst_strobes", strobes(), 10'd0);
        check("rst_retired", bus.retired, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed: add, load with 2 waits, store with no wait, both branches.
        run_instr(3'd2, 0, 1'b0);
        run_instr(3'd0, 2, 1'b0);
        run_instr(3'd1, 0, 1'b0);
        run_instr(3'd6, 0, 1'b1);
        run_instr(3'd6, 0, 1'b0);
        // Ready arrives on the very cycle the timeout would fire.
        run_instr(3'd0, MEM_WAIT_MAX, 1'b0);
        run_instr(3'd1, MEM_WAIT_MAX, 1'b0);

        for (int i = 0; i < 40; i++)
            run_instr(3'($urandom_range(0, 6)), $urandom_range(0, MEM_WAIT_MAX), 1'($urandom));

        // Illegal opcode: sticky trap, then asynchronous exit by reset.
        bus.opcode = 3'd7;
        #1;
        check("ill_fetch", bus.state, 3'd0);
        @(negedge clk);
        bus.opcode = 3'd7;
        #1;
        check("ill_decode", bus.state, 3'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.opcode = 3'($urandom);
            bus.mem_ready = 1'($urandom);
            bus.zero = 1'($urandom);
            #1;
            check("ill_state", bus.state, 3'd7);
            check("ill_trap", bus.trap, 2'b01);
            check("ill_strobes", strobes(), 10'd0);
        end
        pulse_reset("ill_rst");

        // Memory timeout: load with mem_ready stuck low.
        cnt = 0;
        for (k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            bus.opcode = (k <= 1) ? 3'd0 : 3'($urandom);
            bus.mem_ready = 1'b0;
            #1;
            if (bus.state == 3'd7) break;
            if (bus.mem_read) cnt++;
        end
        check("to_mem_read_cycles", cnt, MEM_WAIT_MAX + 1);
        check("to_cycle", k, 3 + MEM_WAIT_MAX + 1);
        check("to_state", bus.state, 3'd7);
        check("to_trap", bus.trap, 2'b10);
        check("to_strobes", strobes(), 10'd0);
        pulse_reset("to_rst");

        // Reset mid-MEM drops mem_read without waiting for an edge.
        for (k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            bus.opcode = (k <= 1) ? 3'd0 : 3'($urandom);
            bus.mem_ready = 1'b0;
            #1;
        end
        check("mid_mem_state", bus.state, 3'd3);
        check("mid_mem_read", bus.mem_read, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_mem_read", bus.mem_read, 1'b0);
        check("mid_rst_state", bus.state, 3'd0);
        exp_retired = 0;
        @(negedge clk);
        reset = 1'b0;

        // Recovery after reset; retired restarts from zero.
        run_instr(3'd2, 0, 1'b0);
        run_instr(3'd0, 1, 1'b0);
        run_instr(3'd1, 3, 1'b0);
        run_instr(3'd6, 0, 1'b1);
        check_retired("retired_after_four");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
